mem_lsu: RTL and testbench

- Load/store unit directly upstream of the byte-addressed data memory.
- Accepts core load/store requests through a valid/ready handshake and checks alignment, range and funct3 legality.
- Buffers stores in a small FIFO that drains one entry per cycle into the memory write port.
- Serves loads through a memory read port; stalls any load that overlaps a pending store and returns a registered response one cycle after acceptance.

---
 rtl/mem_lsu.sv | 104 ++++++++++
 tb/tb_mem_lsu.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit in front of a byte-addressed memory; checks request legality,
// buffers stores in a FIFO drained one per cycle, and stalls loads that overlap pending stores.
module mem_lsu #(
  parameter int RAM_SIZE = 128,
  parameter int ADDR_W   = 9,
  parameter int SB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  input  logic              sb_hold,
  output logic              idle,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_wa,
  output logic [2:0]        mem_wm,
  output logic [31:0]       mem_wd,
  output logic [ADDR_W-1:0] mem_ra,
  output logic [2:0]        mem_rm,
  input  logic [31:0]       mem_rd
);
  localparam int PW = $clog2(SB_DEPTH);
  logic [ADDR_W-1:0] r_sa [SB_DEPTH];
  logic [2:0]        r_sm [SB_DEPTH];
  logic [31:0]       r_sd [SB_DEPTH];
  logic [PW:0]       r_wp, r_rp;
  logic [PW:0]       w_cnt;
  logic [PW-1:0]     w_off;
  logic [2:0]        w_size;
  logic [32:0]       w_last;
  logic [ADDR_W:0]   w_a, w_b;
  logic              w_empty, w_full, w_err, w_hit, w_acc, w_push;

  function automatic logic [2:0] f_size(input logic [2:0] f);
    return (f[1:0] == 2'b10) ? 3'd4 : f[0] ? 3'd2 : 3'd1;
  endfunction

  assign w_size  = f_size(req_funct3);
  // Range check in 33 bits so addresses near 2^32 cannot wrap into range
  assign w_last  = {1'b0, req_addr} + {30'd0, w_size} - 33'd1;
  assign w_err   = (&req_funct3[1:0]) || (req_funct3 == 3'b110) || (req_we && req_funct3[2])
                || (w_size == 3'd2 && req_addr[0]) || (w_size == 3'd4 && |req_addr[1:0])
                || (w_last >= 33'(RAM_SIZE));
  assign w_cnt   = r_wp - r_rp;
  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[PW] != r_rp[PW]) && (r_wp[PW-1:0] == r_rp[PW-1:0]);
  assign w_a     = {1'b0, req_addr[ADDR_W-1:0]};

  // Conservative hazard: the head being drained this cycle still counts as pending
  always_comb begin
    w_hit = 1'b0;
    w_off = '0;
    w_b   = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      w_off = PW'(i) - r_rp[PW-1:0];
      w_b   = {1'b0, r_sa[i]};
      w_hit = w_hit || (({1'b0, w_off} < w_cnt)
                    && (w_a < w_b + (ADDR_W+1)'(f_size(r_sm[i])))
                    && (w_b < w_a + (ADDR_W+1)'(w_size)));
    end
  end

  assign req_ready = w_err || (req_we ? !w_full : !w_hit);
  assign w_acc     = req_valid && req_ready;
  assign w_push    = w_acc && req_we && !w_err;
  assign mem_we    = !w_empty && !sb_hold;
  assign mem_wa    = r_sa[r_rp[PW-1:0]];
  assign mem_wm    = r_sm[r_rp[PW-1:0]];
  assign mem_wd    = r_sd[r_rp[PW-1:0]];
  assign mem_ra    = req_addr[ADDR_W-1:0];
  assign mem_rm    = req_funct3;
  assign idle      = w_empty;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_wp       <= '0;
      r_rp       <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + (PW+1)'(1);
      if (mem_we) r_rp <= r_rp + (PW+1)'(1);
      resp_valid <= w_acc;
      if (w_acc) begin
        resp_err   <= w_err;
        resp_rdata <= (w_err || req_we) ? '0 : mem_rd;
      end
    end

  always_ff @(posedge clk)
    if (w_push) begin
      r_sa[r_wp[PW-1:0]] <= req_addr[ADDR_W-1:0];
      r_sm[r_wp[PW-1:0]] <= req_funct3;
      r_sd[r_wp[PW-1:0]] <= req_wdata;
    end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: randomized + directed bench for mem_lsu against a queue-based reference model
// and a behavioural byte memory attached to the write/read ports.
module tb_mem_lsu;
  localparam int RAM = 128;
  localparam int SB  = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        sb_hold, idle, mem_we;
  logic [8:0]  mem_wa, mem_ra;
  logic [2:0]  mem_wm, mem_rm;
  logic [31:0] mem_wd, mem_rd;

  mem_lsu dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .sb_hold(sb_hold), .idle(idle), .mem_we(mem_we), .mem_wa(mem_wa), .mem_wm(mem_wm),
    .mem_wd(mem_wd), .mem_ra(mem_ra), .mem_rm(mem_rm), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [8:0] a; logic [2:0] f; logic [31:0] d;} st_t;
  st_t         sq[$];
  logic [7:0]  tmem [0:515];
  logic [7:0]  ref_mem [0:131];
  logic [31:0] env_w;
  logic        e_rv, e_err;
  logic [31:0] e_rd;
  int          n_chk = 0, n_err = 0;

  function automatic int sz_of(input logic [2:0] f);
    return (f == 3'b010) ? 4 : (f[1:0] == 2'b01) ? 2 : 1;
  endfunction

  function automatic logic [31:0] ld(input logic [31:0] w, input logic [2:0] f);
    case (f)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'd0, w[7:0]};
      3'b101:  return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic is_err(input logic we, input logic [31:0] a, input logic [2:0] f);
    int     sz   = sz_of(f);
    longint last = longint'({32'd0, a}) + longint'(sz) - 1;
    return f == 3'd3 || f == 3'd6 || f == 3'd7 || (we && f[2]) || (a % sz != 0) || last >= RAM;
  endfunction

  function automatic logic ovl(input logic [31:0] a, input logic [2:0] f);
    int x = int'(a[8:0]);
    foreach (sq[i])
      if (x < int'(sq[i].a) + sz_of(sq[i].f) && int'(sq[i].a) < x + sz_of(f)) return 1'b1;
    return 1'b0;
  endfunction

  // Behavioural memory device seen by the DUT
  always_comb begin
    env_w  = {tmem[int'(mem_ra)+3], tmem[int'(mem_ra)+2], tmem[int'(mem_ra)+1], tmem[int'(mem_ra)]};
    mem_rd = ld(env_w, mem_rm);
  end

  always @(posedge clk)
    if (mem_we)
      for (int k = 0; k < sz_of(mem_wm); k++) tmem[int'(mem_wa)+k] <= mem_wd[8*k +: 8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
  endtask

  // One clock: drive at posedge+1, check combinational outputs at negedge, responses at next posedge+1
  task automatic step(input logic v, input logic we, input logic [31:0] a, input logic [2:0] f,
                      input logic [31:0] d, input logic h, output logic acc);
    logic e_e, e_rdy, e_we;
    logic [31:0] w;
    req_valid = v; req_we = we; req_addr = a; req_funct3 = f; req_wdata = d; sb_hold = h;
    @(negedge clk);
    e_e   = is_err(we, a, f);
    e_rdy = e_e ? 1'b1 : we ? (sq.size() < SB) : !ovl(a, f);
    e_we  = sq.size() != 0 && !h;
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("idle", 32'(idle), 32'(sq.size() == 0));
    if (e_we) begin
      chk("mem_wa", 32'(mem_wa), 32'(sq[0].a));
      chk("mem_wm", 32'(mem_wm), 32'(sq[0].f));
      chk("mem_wd", mem_wd, sq[0].d);
    end
    acc  = v && e_rdy;
    e_rv = acc;
    if (acc) begin
      e_err = e_e;
      if (e_e || we) e_rd = 32'd0;
      else begin
        w    = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
        e_rd = ld(w, f);
      end
    end
    if (e_we) begin
      for (int k = 0; k < sz_of(sq[0].f); k++) ref_mem[int'(sq[0].a)+k] = sq[0].d[8*k +: 8];
      void'(sq.pop_front());
    end
    if (acc && we && !e_e) sq.push_back('{a: a[8:0], f: f, d: d});
    @(posedge clk); #1;
    chk("resp_valid", 32'(resp_valid), 32'(e_rv));
    chk("resp_err", 32'(resp_err), 32'(e_err));
    chk("resp_rdata", resp_rdata, e_rd);
  endtask

  task automatic req_until(input logic we, input logic [31:0] a, input logic [2:0] f,
                           input logic [31:0] d, input logic h);
    logic acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) step(1'b1, we, a, f, d, h, acc);
    chk("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic do_reset;
    #2 reset_n = 1'b0;
    #1 chk_rst;
    sq.delete();
    e_rv = 1'b0; e_err = 1'b0; e_rd = 32'd0;
    req_valid = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  logic        acc;
  logic        rwe;
  logic [2:0]  rf;
  logic [31:0] ra;
  logic [2:0]  legal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  int          diffs;

  initial begin
    for (int i = 0; i < 516; i++) tmem[i] = 8'(i * 37 + 5);
    for (int i = 0; i < 132; i++) ref_mem[i] = 8'(i * 37 + 5);
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_funct3 = '0; req_wdata = '0; sb_hold = 1'b0;
    e_rv = 1'b0; e_err = 1'b0; e_rd = 32'd0;
    @(posedge clk); #1 chk_rst;
    reset_n = 1'b1;
    step(1'b1, 1'b1, 8, 3'b010, 32'h11223344, 1'b0, acc);
    req_until(1'b0, 8, 3'b010, 0, 1'b0);
    chk("lw8", resp_rdata, 32'h11223344);
    req_until(1'b0, 11, 3'b100, 0, 1'b0);
    chk("lbu11", resp_rdata, 32'h00000011);
    req_until(1'b1, 12, 3'b000, 32'h80, 1'b0);
    req_until(1'b0, 12, 3'b000, 0, 1'b0);
    chk("lb12", resp_rdata, 32'hFFFFFF80);
    req_until(1'b0, 12, 3'b100, 0, 1'b0);
    chk("lbu12", resp_rdata, 32'h00000080);
    req_until(1'b1, 16, 3'b010, 32'hA5A58001, 1'b0);
    req_until(1'b0, 18, 3'b001, 0, 1'b0);
    chk("lh18", resp_rdata, 32'hFFFFA5A5);
    for (int k = 0; k < 4; k++) req_until(1'b1, 32 + 4 * k, 3'b010, $urandom, 1'b1);
    step(1'b1, 1'b1, 48, 3'b010, 32'hCAFEF00D, 1'b1, acc);
    req_until(1'b1, 48, 3'b010, 32'hCAFEF00D, 1'b0);
    req_until(1'b0, 6, 3'b010, 0, 1'b0);
    chk("lw6_err", 32'(resp_err), 32'd1);
    req_until(1'b1, 124, 3'b010, 32'h0BADBEEF, 1'b0);
    chk("sw124_ok", 32'(resp_err), 32'd0);
    req_until(1'b1, 126, 3'b010, 32'h12345678, 1'b0);
    chk("sw126_err", 32'(resp_err), 32'd1);
    req_until(1'b0, 20, 3'b011, 0, 1'b0);
    chk("f3_011_err", 32'(resp_err), 32'd1);
    req_until(1'b1, 20, 3'b100, 32'h55, 1'b0);
    chk("sbu_store_err", 32'(resp_err), 32'd1);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 0, 3'b000, 0, 1'b0, acc);
    for (int k = 0; k < 3; k++) req_until(1'b1, 64 + 4 * k, 3'b010, 32'hDEAD0000 + k, 1'b1);
    step(1'b0, 1'b0, 0, 3'b000, 0, 1'b1, acc);
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 0, 3'b000, 0, 1'b0, acc);
    for (int n = 0; n < 400; n++) begin
      rwe = 1'($urandom_range(0, 1));
      rf  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7))
          : rwe ? 3'($urandom_range(0, 2)) : legal[$urandom_range(0, 4)];
      ra  = 32'($urandom_range(0, 40));
      if ($urandom_range(0, 3) != 0) ra = ra & ~32'(sz_of(rf) - 1);
      if ($urandom_range(0, 9) == 0) ra = 32'($urandom_range(118, 135));
      if ($urandom_range(0, 19) == 0) ra = $urandom;
      step(1'($urandom_range(0, 4) != 0), rwe, ra, rf, $urandom,
           1'($urandom_range(0, 4) == 0), acc);
    end
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 0, 3'b000, 0, 1'b0, acc);
    diffs = 0;
    for (int i = 0; i < RAM; i++) if (tmem[i] !== ref_mem[i]) diffs++;
    chk("mem_contents", 32'(diffs), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
